// File: rtl/traffic_light_conflict_monitor_pkg.sv
// rtl/traffic_light_conflict_monitor_pkg.sv - shared traffic-light lamp encodings, fault codes and timer width
package traffic_light_conflict_monitor_pkg;

  localparam int STATE_TIMER_BITS_DEFAULT = 16;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  typedef enum logic [2:0] {
    FC_NONE         = 3'd0,
    FC_CONFLICT     = 3'd1,
    FC_INVALID      = 3'd2,
    FC_YELLOW_SKIP  = 3'd3,
    FC_SHORT_YELLOW = 3'd4
  } faultCode_t;

  typedef enum logic [1:0] {
    ST_BLANK = 2'd0,
    ST_ARMED = 2'd1,
    ST_FAULT = 2'd2
  } monState_t;

  function automatic logic isValidLamp(input logic [2:0] lamp);
    return $onehot(lamp);
  endfunction

  function automatic logic isNonRed(input logic [2:0] lamp);
    return (lamp == LAMP_GRN) || (lamp == LAMP_YEL);
  endfunction

endpackage

// File: rtl/traffic_light_conflict_monitor_lamp_sequence_checker.sv
// rtl/traffic_light_conflict_monitor_lamp_sequence_checker.sv - per-road lamp history, yellow timing and encoding flags (CONFLICT_MONITOR_YELLOW_CHECK_EN)
module lamp_sequence_checker
  import traffic_light_conflict_monitor_pkg::*;
#(
  parameter int MIN_YELLOW_COUNT = 30,
  parameter int STATE_TIMER_BITS = STATE_TIMER_BITS_DEFAULT
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] lamp,
  output logic       yellowSkip,
  output logic       shortYellow,
  output logic       invalid
);

  assign invalid = !isValidLamp(lamp);

`ifdef CONFLICT_MONITOR_YELLOW_CHECK_EN
  localparam logic [STATE_TIMER_BITS-1:0] MIN_YEL = STATE_TIMER_BITS'(MIN_YELLOW_COUNT);

  logic [2:0]                  prevLamp;
  logic [STATE_TIMER_BITS-1:0] yelCnt;

  // Track previous lamp and the length of the current yellow run in every monitor state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prevLamp <= LAMP_RED;
      yelCnt   <= '0;
    end else begin
      prevLamp <= lamp;
      if (lamp == LAMP_YEL) begin
        if (~&yelCnt) yelCnt <= yelCnt + 1'b1;
      end else begin
        yelCnt <= '0;
      end
    end
  end

  // Green straight to red skips yellow; leaving a yellow run before the minimum is short
  assign yellowSkip  = (prevLamp == LAMP_GRN) && (lamp == LAMP_RED);
  assign shortYellow = (yelCnt != '0) && (lamp != LAMP_YEL) && (yelCnt < MIN_YEL);
`else
  logic unusedInputs;
  assign unusedInputs = &{1'b0, clk, reset_n, MIN_YELLOW_COUNT[0], STATE_TIMER_BITS[0]};
  assign yellowSkip   = 1'b0;
  assign shortYellow  = 1'b0;
`endif

endmodule

// File: rtl/traffic_light_conflict_monitor.sv
// rtl/traffic_light_conflict_monitor.sv - lamp conflict monitor FSM with filtered steady-state faults (CONFLICT_MONITOR_YELLOW_CHECK_EN)
module traffic_light_conflict_monitor
  import traffic_light_conflict_monitor_pkg::*;
#(
  parameter int FILTER_COUNT     = 3,
  parameter int MIN_YELLOW_COUNT = 30,
  parameter int BLANK_COUNT      = 16,
  parameter int STATE_TIMER_BITS = STATE_TIMER_BITS_DEFAULT
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] primaryRoadLight_RYG,
  input  logic [2:0] secondaryRoadLight_RYG,
  input  logic       clear_fault,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic       monitor_armed
);

  localparam logic [3:0]                  FILTER_LAST = 4'(FILTER_COUNT - 1);
  localparam logic [STATE_TIMER_BITS-1:0] BLANK_INIT  = STATE_TIMER_BITS'(BLANK_COUNT);

  monState_t                   state;
  logic [STATE_TIMER_BITS-1:0] blankCnt;
  logic [3:0]                  filterCnt;
  logic                        skipP, skipS, shortP, shortS, invP, invS;
  logic                        conflictNow, violationNow, filterHit;
  faultCode_t                  causeCode;

  lamp_sequence_checker #(
    .MIN_YELLOW_COUNT(MIN_YELLOW_COUNT),
    .STATE_TIMER_BITS(STATE_TIMER_BITS)
  ) primaryCheck (
    .clk        (clk),
    .reset_n    (reset_n),
    .lamp       (primaryRoadLight_RYG),
    .yellowSkip (skipP),
    .shortYellow(shortP),
    .invalid    (invP)
  );

  lamp_sequence_checker #(
    .MIN_YELLOW_COUNT(MIN_YELLOW_COUNT),
    .STATE_TIMER_BITS(STATE_TIMER_BITS)
  ) secondaryCheck (
    .clk        (clk),
    .reset_n    (reset_n),
    .lamp       (secondaryRoadLight_RYG),
    .yellowSkip (skipS),
    .shortYellow(shortS),
    .invalid    (invS)
  );

  assign conflictNow  = isNonRed(primaryRoadLight_RYG) && isNonRed(secondaryRoadLight_RYG);
  assign violationNow = conflictNow || invP || invS;
  assign filterHit    = violationNow && (filterCnt == FILTER_LAST);

  // Pick the lowest-numbered cause that would latch on this edge
  always_comb begin
    causeCode = FC_NONE;
    if (filterHit && conflictNow)  causeCode = FC_CONFLICT;
    else if (filterHit)            causeCode = FC_INVALID;
    else if (skipP || skipS)       causeCode = FC_YELLOW_SKIP;
    else if (shortP || shortS)     causeCode = FC_SHORT_YELLOW;
  end

  // Monitor FSM: blank after reset/clear, check while armed, hold fault until a clean clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_BLANK;
      blankCnt      <= BLANK_INIT;
      filterCnt     <= '0;
      fault         <= 1'b0;
      fault_code    <= FC_NONE;
      monitor_armed <= 1'b0;
    end else begin
      case (state)
        ST_BLANK: begin
          filterCnt <= '0;
          if (blankCnt <= STATE_TIMER_BITS'(1)) begin
            state         <= ST_ARMED;
            monitor_armed <= 1'b1;
          end else begin
            blankCnt <= blankCnt - 1'b1;
          end
        end
        ST_ARMED: begin
          if (causeCode != FC_NONE) begin
            state         <= ST_FAULT;
            fault         <= 1'b1;
            fault_code    <= causeCode;
            monitor_armed <= 1'b0;
            filterCnt     <= '0;
          end else if (violationNow) begin
            filterCnt <= filterCnt + 4'd1;
          end else begin
            filterCnt <= '0;
          end
        end
        ST_FAULT: begin
          if (clear_fault && !violationNow) begin
            state      <= ST_BLANK;
            blankCnt   <= BLANK_INIT;
            fault      <= 1'b0;
            fault_code <= FC_NONE;
          end
        end
        default: begin
          state         <= ST_BLANK;
          blankCnt      <= BLANK_INIT;
          filterCnt     <= '0;
          fault         <= 1'b0;
          fault_code    <= FC_NONE;
          monitor_armed <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_traffic_light_conflict_monitor.sv
// tb/tb_traffic_light_conflict_monitor.sv - directed checks of the conflict monitor (CONFLICT_MONITOR_YELLOW_CHECK_EN aware)
module tb_traffic_light_conflict_monitor;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] BAD = 3'b011;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [2:0] primaryLamp;
  logic [2:0] secondaryLamp;
  logic       clearFault;
  logic       dut1Fault, dut1Armed, dut2Fault, dut2Armed;
  logic [2:0] dut1Code, dut2Code;

  int assertCount = 0;
  int failCount   = 0;

  always #5 clk = ~clk;

  traffic_light_conflict_monitor dut1 (
    .clk                   (clk),
    .reset_n               (reset_n),
    .primaryRoadLight_RYG  (primaryLamp),
    .secondaryRoadLight_RYG(secondaryLamp),
    .clear_fault           (clearFault),
    .fault                 (dut1Fault),
    .fault_code            (dut1Code),
    .monitor_armed         (dut1Armed)
  );

  traffic_light_conflict_monitor #(.FILTER_COUNT(1)) dut2 (
    .clk                   (clk),
    .reset_n               (reset_n),
    .primaryRoadLight_RYG  (primaryLamp),
    .secondaryRoadLight_RYG(secondaryLamp),
    .clear_fault           (clearFault),
    .fault                 (dut2Fault),
    .fault_code            (dut2Code),
    .monitor_armed         (dut2Armed)
  );

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic drive(input logic [2:0] p, input logic [2:0] s, input int n);
    primaryLamp   = p;
    secondaryLamp = s;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkStatus(input string tag, input logic f, input logic [2:0] c, input logic a);
    check({tag, "_fault"}, 8'(dut1Fault), 8'(f));
    check({tag, "_code"},  8'(dut1Code),  8'(c));
    check({tag, "_armed"}, 8'(dut1Armed), 8'(a));
  endtask

  task automatic clearAndRearm(input string tag);
    clearFault = 1'b1;
    drive(R, R, 1);
    clearFault = 1'b0;
    checkStatus({tag, "_cleared"}, 1'b0, 3'd0, 1'b0);
    drive(R, R, 16);
    check({tag, "_rearmed"}, 8'(dut1Armed), 8'd1);
  endtask

  initial begin
    reset_n     = 1'b0;
    clearFault  = 1'b0;
    primaryLamp = R;
    secondaryLamp = R;
    drive(R, R, 2);
    checkStatus("reset", 1'b0, 3'd0, 1'b0);

    reset_n = 1'b1;
    drive(R, R, 15);
    check("blank_15", 8'(dut1Armed), 8'd0);
    drive(R, R, 1);
    check("blank_16", 8'(dut1Armed), 8'd1);

    // Normal full cycle with 30-cycle yellows
    drive(G, R, 5);  check("norm_pg", 8'(dut1Fault), 8'd0);
    drive(Y, R, 30); check("norm_py", 8'(dut1Fault), 8'd0);
    drive(R, R, 3);  check("norm_rr1", 8'(dut1Fault), 8'd0);
    drive(R, G, 5);  check("norm_sg", 8'(dut1Fault), 8'd0);
    drive(R, Y, 30); check("norm_sy", 8'(dut1Fault), 8'd0);
    drive(R, R, 3);  checkStatus("norm_end", 1'b0, 3'd0, 1'b1);

    // Two-sample conflict is filtered out, leaving yellow after a full 30-sample run
    drive(R, Y, 28);
    drive(G, Y, 2);  check("conf2_fault", 8'(dut1Fault), 8'd0);
    drive(G, R, 1);  check("conf2_end", 8'(dut1Fault), 8'd0);

    // Three-sample conflict latches code 1 on the third edge
    drive(G, G, 2);  check("conf3_e2", 8'(dut1Fault), 8'd0);
    drive(G, G, 1);  checkStatus("conf3_e3", 1'b1, 3'd1, 1'b0);
    clearFault = 1'b1;
    drive(G, G, 1);  checkStatus("conf_clr_ignored", 1'b1, 3'd1, 1'b0);
    drive(G, R, 1);
    clearFault = 1'b0;
    checkStatus("conf_cleared", 1'b0, 3'd0, 1'b0);
    drive(G, R, 15); check("conf_blank15", 8'(dut1Armed), 8'd0);
    drive(G, R, 1);  check("conf_rearm", 8'(dut1Armed), 8'd1);

    // Invalid encoding latches code 2; clear ignored while still invalid
    drive(BAD, R, 2); check("inv_e2", 8'(dut1Fault), 8'd0);
    drive(BAD, R, 1); checkStatus("inv_e3", 1'b1, 3'd2, 1'b0);
    clearFault = 1'b1;
    drive(BAD, R, 2); checkStatus("inv_clr_ignored", 1'b1, 3'd2, 1'b0);
    drive(R, R, 1);
    clearFault = 1'b0;
    checkStatus("inv_cleared", 1'b0, 3'd0, 1'b0);
    drive(R, R, 15); check("inv_blank15", 8'(dut1Armed), 8'd0);
    drive(R, R, 1);  check("inv_rearm", 8'(dut1Armed), 8'd1);

    // Green straight to red, then a 10-sample yellow
    drive(G, R, 2);
    drive(R, R, 1);
`ifdef CONFLICT_MONITOR_YELLOW_CHECK_EN
    checkStatus("skip", 1'b1, 3'd3, 1'b0);
    clearAndRearm("skip");
`else
    checkStatus("skip_off", 1'b0, 3'd0, 1'b1);
    clearFault = 1'b1;
    drive(R, R, 1);
    clearFault = 1'b0;
    checkStatus("clear_in_armed", 1'b0, 3'd0, 1'b1);
`endif
    drive(Y, R, 10);
    drive(R, R, 1);
`ifdef CONFLICT_MONITOR_YELLOW_CHECK_EN
    checkStatus("short", 1'b1, 3'd4, 1'b0);
    clearAndRearm("short");
`else
    checkStatus("short_off", 1'b0, 3'd0, 1'b1);
`endif

    // Reset both monitors, then conflict and short yellow on the same edge
    reset_n = 1'b0;
    drive(R, R, 1);
    checkStatus("rst2", 1'b0, 3'd0, 1'b0);
    reset_n = 1'b1;
    drive(R, R, 16);
    check("dut2_armed", 8'(dut2Armed), 8'd1);
    drive(Y, R, 3);
    check("dut2_pre", 8'(dut2Fault), 8'd0);
    drive(G, G, 1);
    check("dut2_fault", 8'(dut2Fault), 8'd1);
    check("dut2_code",  8'(dut2Code),  8'd1);
`ifdef CONFLICT_MONITOR_YELLOW_CHECK_EN
    checkStatus("dut1_short_vs_filter", 1'b1, 3'd4, 1'b0);
`else
    checkStatus("dut1_filtering", 1'b0, 3'd0, 1'b1);
`endif

    // Asynchronous reset clears a latched fault without a clock edge
    reset_n = 1'b0;
    #2;
    check("async_fault", 8'(dut2Fault), 8'd0);
    check("async_code",  8'(dut2Code),  8'd0);
    check("async_armed", 8'(dut2Armed), 8'd0);
    check("async_dut1_armed", 8'(dut1Armed), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
